// File: rtl/u_icache.sv
// Direct-mapped read-only icache: same-cycle hit, miss refills one line in LINE_WORDS beats + 1 cycle.
// Stalls u_if via busywait_o during refill; ICACHE_STATS_EN adds hit/miss counters.
module u_icache #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_req_i,
  input  logic [29:0] fetch_addr_i,
  output logic        busywait_o,
  output logic [31:0] instr_o,
  input  logic        invalidate_i,
  output logic        mem_req_o,
  output logic [29:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [IW-1:0] idx;
    logic [OW-1:0] off;
  } addr_t;

  typedef enum logic {IDLE, REFILL} state_t;

  addr_t         fa;
  state_t        state, state_nxt;
  logic [31:0]   data_q [LINES][LINE_WORDS];
  logic [TW-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q;
  logic [TW-1:0] tag_l;
  logic [IW-1:0] idx_l;
  logic [OW-1:0] cnt;
  logic          pending;
  logic          hit, start, last_beat;

  assign fa         = addr_t'(fetch_addr_i);
  assign mem_req_o  = (state == REFILL);
  assign mem_addr_o = {tag_l, idx_l, {OW{1'b0}}};

  always_comb begin
    hit        = fetch_req_i && (state == IDLE) && valid_q[fa.idx] && (tag_q[fa.idx] == fa.tag);
    start      = fetch_req_i && !hit && (state == IDLE);
    last_beat  = (state == REFILL) && mem_rvalid_i && (cnt == OW'(LINE_WORDS - 1));
    busywait_o = fetch_req_i && !hit;
    instr_o    = hit ? data_q[fa.idx][fa.off] : NOP;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REFILL;
      REFILL:  if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      tag_l   <= '0;
      idx_l   <= '0;
      cnt     <= '0;
      pending <= 1'b0;
    end else if (state == IDLE) begin
      if (invalidate_i) valid_q <= '0;
      if (start) begin
        tag_l   <= fa.tag;
        idx_l   <= fa.idx;
        cnt     <= '0;
        pending <= invalidate_i;
      end
    end else begin
      if (invalidate_i) pending <= 1'b1;
      if (mem_rvalid_i) cnt <= cnt + 1'b1;
      // A flush seen at any point of the refill also drops the line just filled.
      if (last_beat) begin
        pending <= 1'b0;
        if (pending || invalidate_i) valid_q <= '0;
        else                         valid_q[idx_l] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if ((state == REFILL) && mem_rvalid_i) begin
      data_q[idx_l][cnt] <= mem_rdata_i;
      if (last_beat) tag_q[idx_l] <= tag_l;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit && (hit_cnt_o != 32'hFFFF_FFFF))    hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (start && (miss_cnt_o != 32'hFFFF_FFFF)) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_u_icache.sv
// Directed bench for u_icache: per-cycle vector table plus hand sequences for flush,
// address change mid-refill and asynchronous reset.
module tb_u_icache;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        fetch_req_i = 1'b0;
  logic [29:0] fetch_addr_i = '0;
  logic        busywait_o;
  logic [31:0] instr_o;
  logic        invalidate_i = 1'b0;
  logic        mem_req_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_rvalid_i = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  u_icache dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fetch_req_i  (fetch_req_i),
    .fetch_addr_i (fetch_addr_i),
    .busywait_o   (busywait_o),
    .instr_o      (instr_o),
    .invalidate_i (invalidate_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rvalid_i (mem_rvalid_i)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        req;
    logic [29:0] addr;
    logic        inv;
    logic        rv;
    logic [31:0] rd;
    logic        busy;
    logic [31:0] instr;
    logic        mreq;
    logic [29:0] maddr;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  function automatic void add(input logic req, input logic [29:0] addr, input logic inv,
                              input logic rv, input logic [31:0] rd, input logic busy,
                              input logic [31:0] instr, input logic mreq, input logic [29:0] maddr);
    vec_t v;
    v.req = req; v.addr = addr; v.inv = inv; v.rv = rv; v.rd = rd;
    v.busy = busy; v.instr = instr; v.mreq = mreq; v.maddr = maddr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic drive(input logic req, input logic [29:0] addr, input logic inv,
                       input logic rv, input logic [31:0] rd);
    fetch_req_i  = req;
    fetch_addr_i = addr;
    invalidate_i = inv;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
    #2;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Four in-order beats; fetch address switches from a1 to a2 at beat sw, flush pulses at inv_beat.
  task automatic refill(input logic [29:0] a1, input logic [29:0] a2, input int sw,
                        input logic [29:0] line, input logic [31:0] base, input int inv_beat,
                        input string nm);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, (k < sw) ? a1 : a2, (k == inv_beat), 1'b1, base + 32'(k));
      chk({nm, "_busy"}, 32'(busywait_o), 32'd1);
      chk({nm, "_mreq"}, 32'(mem_req_o), 32'd1);
      chk({nm, "_maddr"}, 32'(mem_addr_o), 32'(line));
      tick();
    end
  endtask

  initial begin
    // Word addresses: 0x40=byte 0x100 (idx0 tag1), 0x140=0x500 (idx0 tag5),
    // 0x48=0x120 (idx2), 0x90=0x240 (idx4 tag2), 0x50=0x140 (idx4 tag1).
    add(1, 'h40, 0, 0, 0,     1, NOP, 0, 'h0);
    for (int k = 0; k < 4; k++) add(1, 'h40, 0, 1, 32'hA0 + 32'(k), 1, NOP, 1, 'h40);
    add(1, 'h40, 0, 0, 0,     0, 'hA0, 0, 'h40);
    add(1, 'h41, 0, 0, 0,     0, 'hA1, 0, 'h40);
    add(1, 'h42, 0, 0, 0,     0, 'hA2, 0, 'h40);
    add(1, 'h43, 0, 0, 0,     0, 'hA3, 0, 'h40);
    add(0, 'h41, 0, 1, 'hDEAD, 0, NOP, 0, 'h40);
    add(1, 'h41, 0, 0, 0,     0, 'hA1, 0, 'h40);
    add(1, 'h140, 0, 0, 0,    1, NOP, 0, 'h40);
    for (int k = 0; k < 4; k++) add(1, 'h140, 0, 1, 32'hB0 + 32'(k), 1, NOP, 1, 'h140);
    add(1, 'h140, 0, 0, 0,    0, 'hB0, 0, 'h140);
    add(1, 'h143, 0, 0, 0,    0, 'hB3, 0, 'h140);
    add(1, 'h40, 0, 0, 0,     1, NOP, 0, 'h140);
    for (int k = 0; k < 4; k++) add(1, 'h40, 0, 1, 32'hA0 + 32'(k), 1, NOP, 1, 'h40);
    add(1, 'h40, 0, 0, 0,     0, 'hA0, 0, 'h40);

    repeat (2) @(posedge clk_i);
    #1;
    drive(0, '0, 0, 0, '0);
    chk("rst_busy", 32'(busywait_o), 32'd0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_mreq", 32'(mem_req_o), 32'd0);
    chk("rst_maddr", 32'(mem_addr_o), 32'd0);
`ifdef ICACHE_STATS_EN
    chk("rst_hits", hit_cnt_o, 32'd0);
    chk("rst_misses", miss_cnt_o, 32'd0);
`endif
    rst_i = 1'b1;
    tick();

    foreach (vecs[i]) begin
`ifdef ICACHE_STATS_EN
      if (i == 9) begin
        chk("stats_hits", hit_cnt_o, 32'd4);
        chk("stats_misses", miss_cnt_o, 32'd1);
      end
`endif
      drive(vecs[i].req, vecs[i].addr, vecs[i].inv, vecs[i].rv, vecs[i].rd);
      chk($sformatf("v%0d_busy", i), 32'(busywait_o), 32'(vecs[i].busy));
      chk($sformatf("v%0d_instr", i), instr_o, vecs[i].instr);
      chk($sformatf("v%0d_mreq", i), 32'(mem_req_o), 32'(vecs[i].mreq));
      chk($sformatf("v%0d_maddr", i), 32'(mem_addr_o), 32'(vecs[i].maddr));
      tick();
    end

    // Flush pulse on beat 2: the line completes but is not kept.
    drive(1, 'h48, 0, 0, 0);
    chk("inv_first_miss", 32'(busywait_o), 32'd1);
    tick();
    refill('h48, 'h48, 4, 'h48, 'hC0, 2, "inv_refill");
    drive(1, 'h48, 0, 0, 0);
    chk("inv_mreq_drop", 32'(mem_req_o), 32'd0);
    chk("inv_refetch_miss", 32'(busywait_o), 32'd1);
    tick();
    refill('h48, 'h48, 4, 'h48, 'hC0, -1, "inv_refill2");
    // Flush in IDLE: this cycle still hits on the old valid bits.
    drive(1, 'h48, 1, 0, 0);
    chk("inv_idle_busy", 32'(busywait_o), 32'd0);
    chk("inv_idle_instr", instr_o, 32'hC0);
    tick();
    // Flush together with a miss: refill runs, the line ends up invalid.
    drive(1, 'h48, 1, 0, 0);
    chk("inv_idle_cleared", 32'(busywait_o), 32'd1);
    tick();
    refill('h48, 'h48, 4, 'h48, 'hC0, -1, "inv_pend_refill");
    drive(1, 'h48, 0, 0, 0);
    chk("inv_pend_miss", 32'(busywait_o), 32'd1);
    tick();
    refill('h48, 'h48, 4, 'h48, 'hC4, -1, "inv_clean_refill");
    drive(1, 'h48, 0, 0, 0);
    chk("inv_clean_busy", 32'(busywait_o), 32'd0);
    chk("inv_clean_instr", instr_o, 32'hC4);
    tick();

    // Fetch address moves to another line during the refill of 0x40.
    drive(1, 'h40, 0, 0, 0);
    chk("sw_first_miss", 32'(busywait_o), 32'd1);
    tick();
    refill('h40, 'h90, 2, 'h40, 'hA0, -1, "sw_old_refill");
    drive(1, 'h90, 0, 0, 0);
    chk("sw_new_busy", 32'(busywait_o), 32'd1);
    chk("sw_new_mreq", 32'(mem_req_o), 32'd0);
    tick();
    refill('h90, 'h90, 4, 'h90, 'hD0, -1, "sw_new_refill");
    drive(1, 'h91, 0, 0, 0);
    chk("sw_new_busy2", 32'(busywait_o), 32'd0);
    chk("sw_new_instr", instr_o, 32'hD1);
    tick();
    drive(1, 'h42, 0, 0, 0);
    chk("sw_old_busy", 32'(busywait_o), 32'd0);
    chk("sw_old_instr", instr_o, 32'hA2);
    tick();

    // Asynchronous reset in the middle of a refill.
    drive(1, 'h50, 0, 0, 0);
    tick();
    drive(1, 'h50, 0, 1, 'hE0);
    chk("arst_pre_mreq", 32'(mem_req_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("arst_mreq", 32'(mem_req_o), 32'd0);
    chk("arst_maddr", 32'(mem_addr_o), 32'd0);
`ifdef ICACHE_STATS_EN
    chk("arst_hits", hit_cnt_o, 32'd0);
    chk("arst_misses", miss_cnt_o, 32'd0);
`endif
    tick();
    rst_i = 1'b1;
    drive(1, 'h90, 0, 0, 0);
    chk("arst_valid_cleared", 32'(busywait_o), 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
